// File: rtl/pipe_out_pkg.sv
// Shared types for the pipeline result FIFO: data word type and optional stats bundle.
package pipe_out_pkg;

  localparam int unsigned PIPE_DATA_W = 32;

  typedef logic [PIPE_DATA_W-1:0] pipe_word_t;

  typedef struct packed {
    logic [31:0] stat_in;
    logic [31:0] stat_out;
    logic [31:0] stat_drop;
  } pipe_out_stats_t;

endpackage

// File: rtl/pipe_out_fifo_mem.sv
// DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
module pipe_out_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // Contents are deliberately not reset; validity is tracked by the pointers.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_out_fifo.sv
// Non-stalling pipeline result FIFO with ready/valid output, occupancy and overflow flags.
// Optional counters of pushes/pops/drops are built when PIPE_OUT_FIFO_STATS_EN is defined.
module pipe_out_fifo
  import pipe_out_pkg::*;
#(
  parameter int unsigned WIDTH     = PIPE_DATA_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow
`ifdef PIPE_OUT_FIFO_STATS_EN
  ,
  output logic [31:0]            stat_in,
  output logic [31:0]            stat_out,
  output logic [31:0]            stat_drop
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne  = PW'(1);
  localparam logic [PW-1:0] AfLevel = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, push, pop, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // flush wins over everything; a full FIFO still accepts a word when it pops in the same cycle.
  assign pop  = !empty && out_ready && !flush;
  assign push = in_valid && (!full || pop) && !flush;
  assign drop = in_valid && full && !pop && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (drop) overflow_d = 1'b1;
    end
    // Pointer difference modulo 2*DEPTH is the occupancy 0..DEPTH.
    count_d       = wr_ptr_d - rd_ptr_d;
    almost_full_d = (count_d >= AfLevel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  pipe_out_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (out_data)
  );

  assign out_valid   = !empty;
  assign count       = count_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

`ifdef PIPE_OUT_FIFO_STATS_EN
  pipe_out_stats_t stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (flush) begin
      stats_d = '0;
    end else begin
      if (push) stats_d.stat_in   = stats_q.stat_in + 32'd1;
      if (pop)  stats_d.stat_out  = stats_q.stat_out + 32'd1;
      if (drop) stats_d.stat_drop = stats_q.stat_drop + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign stat_in   = stats_q.stat_in;
  assign stat_out  = stats_q.stat_out;
  assign stat_drop = stats_q.stat_drop;
`endif

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Randomised and directed bench for pipe_out_fifo against a queue-based reference model.
module tb_pipe_out_fifo;
  import pipe_out_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AF_MARGIN = 2;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  pipe_word_t    in_data;
  logic          out_valid;
  logic          out_ready;
  pipe_word_t    out_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow;
`ifdef PIPE_OUT_FIFO_STATS_EN
  logic [31:0]   stat_in, stat_out, stat_drop;
  int unsigned   m_in, m_out, m_drop;
`endif

  int         errors = 0;
  int         checks = 0;
  pipe_word_t q[$];
  bit         m_ovf;

  always #5 clk = ~clk;

  pipe_out_fifo #(
    .WIDTH     (PIPE_DATA_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
`ifdef PIPE_OUT_FIFO_STATS_EN
    ,
    .stat_in     (stat_in),
    .stat_out    (stat_out),
    .stat_drop   (stat_drop)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 1'b0;
`ifdef PIPE_OUT_FIFO_STATS_EN
    m_in = 0; m_out = 0; m_drop = 0;
`endif
  endtask

  // Reference behaviour of one clock edge, evaluated on the inputs held across it.
  task automatic model_edge();
    bit do_pop;
    if (flush) begin
      model_clear();
    end else begin
      do_pop = (q.size() != 0) && out_ready;
      if (do_pop) begin
        void'(q.pop_front());
`ifdef PIPE_OUT_FIFO_STATS_EN
        m_out++;
`endif
      end
      if (in_valid) begin
        if (q.size() < DEPTH) begin
          q.push_back(in_data);
`ifdef PIPE_OUT_FIFO_STATS_EN
          m_in++;
`endif
        end else begin
          m_ovf = 1'b1;
`ifdef PIPE_OUT_FIFO_STATS_EN
          m_drop++;
`endif
        end
      end
    end
  endtask

  task automatic check_state();
    check_eq("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) check_eq("out_data", out_data, q[0]);
    check_eq("count", count, q.size());
    check_eq("almost_full", almost_full, q.size() >= DEPTH - AF_MARGIN);
    check_eq("overflow", overflow, m_ovf);
`ifdef PIPE_OUT_FIFO_STATS_EN
    check_eq("stat_in", stat_in, m_in);
    check_eq("stat_out", stat_out, m_out);
    check_eq("stat_drop", stat_drop, m_drop);
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step(input bit iv, input pipe_word_t d, input bit rdy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_clear();
    #12;
    check_state();
    @(negedge clk);
    rst = 1'b0;

    // Trickle with consumer ready: words emerge one cycle after push, count stays <= 1.
    step(1, 9, 1, 0);
    check_eq("t1_first", out_data, 9);
    step(1, 2, 1, 0);
    step(0, 0, 1, 0);
    step(1, 13, 1, 0);
    step(0, 0, 1, 0);
    check_eq("t1_empty", out_valid, 0);

    // Fill to full, then a dropped word sets sticky overflow; drain yields 1..8.
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0);
    check_eq("t2_full", count, 8);
    step(1, 99, 0, 0);
    check_eq("t2_ovf", overflow, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    check_eq("t2_drained", out_valid, 0);
    check_eq("t2_sticky", overflow, 1);

    // Full with push and pop together.
    step(0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0);
    step(1, 50, 1, 0);
    check_eq("t3_count", count, 8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // flush with concurrent in_valid discards the word.
    for (int i = 1; i <= 3; i++) step(1, 100 + i, 0, 0);
    step(1, 77, 0, 1);
    check_eq("t4_count", count, 0);
    check_eq("t4_valid", out_valid, 0);
    step(0, 0, 1, 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 1; i <= 4; i++) step(1, 200 + i, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_eq("t5_count", count, 0);
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_af", almost_full, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 123, 0, 0);
    check_eq("t5_first", out_data, 123);
    step(0, 0, 1, 0);

`ifdef PIPE_OUT_FIFO_STATS_EN
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 300 + i, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    check_eq("t6_in", stat_in, 8);
    check_eq("t6_drop", stat_drop, 2);
    check_eq("t6_out", stat_out, 8);
`endif

    // Random traffic with varying consumer throughput.
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 95);
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 99) < 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
